// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants for the seven-segment display slice.
//   ANODE_OFF            : level that switches a common-anode digit off (active-low select)
//   SEG_BLANK            : segment pattern with every segment dark (active-low)
//   DEFAULT_CLK_HZ       : board clock the refresh defaults are derived from
//   DEFAULT_REFRESH_DIV  : cycles per digit slot (1 ms at 100 MHz)
//   DEFAULT_BLANK_CYCLES : anti-ghosting dead time at the start of each slot
package seven_segment_scanner_pkg;

  localparam logic       ANODE_OFF            = 1'b1;
  localparam logic [6:0] SEG_BLANK            = 7'h7F;
  localparam int         DEFAULT_CLK_HZ       = 100_000_000;
  localparam int         DEFAULT_REFRESH_DIV  = DEFAULT_CLK_HZ / 1000;
  localparam int         DEFAULT_BLANK_CYCLES = 1000;

endpackage

// File: rtl/seven_segment_scanner_decoder.sv
// Hex nibble to seven-segment decoder for a common-anode display.
//   nibble  : input  [3:0] hex digit to show
//   segment : output [6:0] active-low segments, bit 0 = a ... bit 6 = g
module seven_segment
  import seven_segment_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segment
);

  always_comb begin
    segment = SEG_BLANK;
    case (nibble)
      4'h0: segment = 7'b1000000;
      4'h1: segment = 7'b1111001;
      4'h2: segment = 7'b0100100;
      4'h3: segment = 7'b0110000;
      4'h4: segment = 7'b0011001;
      4'h5: segment = 7'b0010010;
      4'h6: segment = 7'b0000010;
      4'h7: segment = 7'b1111000;
      4'h8: segment = 7'b0000000;
      4'h9: segment = 7'b0010000;
      4'hA: segment = 7'b0001000;
      4'hB: segment = 7'b0000011;
      4'hC: segment = 7'b1000110;
      4'hD: segment = 7'b0100001;
      4'hE: segment = 7'b0000110;
      4'hF: segment = 7'b0001110;
      default: segment = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scanner for a multi-digit common-anode hex display.
// A double-buffered word is committed only on frame boundaries so the
// display never tears.
//   clk        : input                  system clock, rising edge
//   reset_n    : input                  synchronous active-low reset
//   data_in    : input  [4*NUM_DIGITS]  value to show, digit 0 in bits [3:0]
//   data_valid : input                  load strobe, sampled every cycle
//   digit_en   : input  [NUM_DIGITS]    per-digit enable (0 = anode stays off)
//   dp_in      : input  [NUM_DIGITS]    per-digit decimal point request
//   segment    : output [6:0]           active-low segments a..g
//   dp         : output                 active-low decimal point
//   anode      : output [NUM_DIGITS]    active-low digit selects
//   load_ack   : output                 one-cycle pulse when a word is committed
//   frame_done : output                 high on the last cycle of the last slot
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    data_valid,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    load_ack,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [SW-1:0] slotCnt, slotNext;
  logic [IW-1:0] digitIdx, idxNext;
  logic [DW-1:0] pending, committed, committedNext;
  logic          pendingFlag;
  logic [3:0]    nibble, nibbleNext;
  logic          slotWrap, frameEdge, commitNow, slotActive, digitOn;
  logic [NUM_DIGITS-1:0] anodeNext;
  logic          dpNext, frameNext;

  // Outputs are registered from the next-state counters (and the next
  // committed word) so they line up with the slot they belong to.
  always_comb begin
    slotWrap  = (slotCnt == SLOT_LAST);
    frameEdge = slotWrap && (digitIdx == IDX_LAST);
    slotNext  = slotWrap ? '0 : slotCnt + 1'b1;
    idxNext   = digitIdx;
    if (slotWrap) begin
      idxNext = (digitIdx == IDX_LAST) ? '0 : digitIdx + 1'b1;
    end

    // A strobe landing on the boundary wins over an older pending word.
    committedNext = committed;
    commitNow     = 1'b0;
    if (frameEdge) begin
      if (data_valid) begin
        committedNext = data_in;
        commitNow     = 1'b1;
      end else if (pendingFlag) begin
        committedNext = pending;
        commitNow     = 1'b1;
      end
    end

    slotActive = (32'(slotNext) >= BLANK_CYCLES);
    digitOn    = slotActive && digit_en[idxNext];
    anodeNext  = {NUM_DIGITS{ANODE_OFF}};
    if (digitOn) begin
      anodeNext[idxNext] = ~ANODE_OFF;
    end
    dpNext     = ~(dp_in[idxNext] & digitOn);
    frameNext  = (slotNext == SLOT_LAST) && (idxNext == IDX_LAST);
    nibbleNext = committedNext[{idxNext, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slotCnt     <= '0;
      digitIdx    <= '0;
      pending     <= '0;
      committed   <= '0;
      pendingFlag <= 1'b0;
      nibble      <= '0;
      anode       <= {NUM_DIGITS{ANODE_OFF}};
      dp          <= 1'b1;
      load_ack    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      slotCnt    <= slotNext;
      digitIdx   <= idxNext;
      committed  <= committedNext;
      nibble     <= nibbleNext;
      anode      <= anodeNext;
      dp         <= dpNext;
      load_ack   <= commitNow;
      frame_done <= frameNext;
      if (commitNow) begin
        pendingFlag <= 1'b0;
      end else if (data_valid) begin
        pending     <= data_in;
        pendingFlag <= 1'b1;
      end
    end
  end

  seven_segment decoder (
    .nibble  (nibble),
    .segment (segment)
  );

endmodule
